// File: rtl/ring_count.sv
// Ring counter: counts hysteresis-qualified threshold crossings of a sample
// stream inside a hit window and captures the count when the window closes.
module ring_count #(
   parameter int unsigned DW = 16,
   parameter int unsigned CW = 16
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic [DW-1:0] sm_data,
   input  logic          sm_vld,
   input  logic [DW-1:0] cfg_th,
   input  logic [DW-1:0] cfg_hys,
   input  logic [1:0]    cfg_mode,
   input  logic          stu_now_hit,
   input  logic          stu_now_lock,
   input  logic          force_end,
   output logic [CW-1:0] stu_ring,
   output logic [CW-1:0] stu_first,
   output logic          stu_ovf,
   output logic [CW-1:0] ph_ring,
   output logic          ph_vld
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIT  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t        state_q, state_d;
   logic          lvl_q, lvl_d;
   logic          hit_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] tmr_q, tmr_d;
   logic [CW-1:0] first_q, first_d;
   logic          ovf_q, ovf_d;

   logic [DW-1:0] lo_th;
   logic          rise_evt, fall_evt, evt;
   logic          win_open, win_close;
   logic [CW-1:0] tmr_inc, cnt_upd, first_upd;
   logic          ovf_upd;
   logic          capture;

   // Lower threshold saturates at zero when hysteresis exceeds the threshold.
   assign lo_th = (cfg_th > cfg_hys) ? (cfg_th - cfg_hys) : '0;

   always_comb begin
      lvl_d = lvl_q;
      if (sm_vld) begin
         if (sm_data >= cfg_th) begin
            lvl_d = 1'b1;
         end else if (sm_data < lo_th) begin
            lvl_d = 1'b0;
         end
      end
   end

   assign rise_evt = ~lvl_q & lvl_d;
   assign fall_evt = lvl_q & ~lvl_d;

   always_comb begin
      case (cfg_mode)
         2'd0:    evt = rise_evt;
         2'd1:    evt = fall_evt;
         default: evt = rise_evt | fall_evt;
      endcase
   end

   assign win_open  = stu_now_hit & ~hit_d;
   assign win_close = ~stu_now_hit & hit_d;

   // Per-cycle update while counting; also the value captured on close.
   always_comb begin
      tmr_inc   = (tmr_q == CNT_MAX) ? tmr_q : tmr_q + CNT_ONE;
      cnt_upd   = cnt_q;
      ovf_upd   = ovf_q;
      first_upd = first_q;
      if (evt) begin
         if (cnt_q == CNT_MAX) begin
            ovf_upd = 1'b1;
         end else begin
            cnt_upd = cnt_q + CNT_ONE;
         end
         if ((cnt_q == CNT_ONE) && !ovf_q) begin
            first_upd = tmr_inc;
         end
      end
   end

   assign capture = (state_q == ST_HIT) & win_close;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      first_d = first_q;
      ovf_d   = ovf_q;
      if (force_end) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         tmr_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_open) begin
                  state_d = ST_HIT;
                  cnt_d   = CNT_ONE;
                  ovf_d   = 1'b0;
                  tmr_d   = '0;
                  first_d = '1;
               end
            end
            ST_HIT: begin
               cnt_d   = cnt_upd;
               ovf_d   = ovf_upd;
               first_d = first_upd;
               tmr_d   = tmr_inc;
               if (win_close) begin
                  if (stu_now_lock) begin
                     state_d = ST_LOCK;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                     ovf_d   = 1'b0;
                  end
               end
            end
            ST_LOCK: begin
               if (win_open) begin
                  state_d = ST_HIT;
                  cnt_d   = CNT_ONE;
                  ovf_d   = 1'b0;
                  tmr_d   = '0;
                  first_d = '1;
               end else if (!stu_now_lock) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lvl_q   <= 1'b0;
         hit_d   <= 1'b0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         first_q <= '1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         hit_d   <= stu_now_hit;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
      end
   end

   // Capture uses the pre-clear update so a simultaneous force_end still records.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         stu_ring  <= '0;
         stu_first <= '0;
         stu_ovf   <= 1'b0;
         ph_vld    <= 1'b0;
      end else begin
         ph_vld <= capture & ~force_end;
         if (capture) begin
            stu_ring  <= cnt_upd;
            stu_first <= first_upd;
            stu_ovf   <= ovf_upd;
         end
      end
   end

   assign ph_ring = stu_ring;

endmodule

// File: tb/tb_ring_count.sv
// Bench for ring_count: directed scenarios plus randomized windows, checked
// against a window/event-count model on a 16-bit and a 4-bit counter instance.
module tb_ring_count;

   logic        clk_sys = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] sm_data = 16'd80;
   logic        sm_vld = 1'b1;
   logic [15:0] cfg_th = 16'd100;
   logic [15:0] cfg_hys = 16'd10;
   logic [1:0]  cfg_mode = 2'd0;
   logic        stu_now_hit = 1'b0;
   logic        stu_now_lock = 1'b0;
   logic        force_end = 1'b0;

   logic [15:0] a_ring, a_first, a_ph_ring;
   logic        a_ovf, a_ph_vld;
   logic [3:0]  b_ring, b_first, b_ph_ring;
   logic        b_ovf, b_ph_vld;

   int total = 0;
   int bad = 0;

   always #5 clk_sys = ~clk_sys;

   ring_count u_a (
      .clk_sys(clk_sys), .rst_n(rst_n), .sm_data(sm_data), .sm_vld(sm_vld),
      .cfg_th(cfg_th), .cfg_hys(cfg_hys), .cfg_mode(cfg_mode),
      .stu_now_hit(stu_now_hit), .stu_now_lock(stu_now_lock), .force_end(force_end),
      .stu_ring(a_ring), .stu_first(a_first), .stu_ovf(a_ovf),
      .ph_ring(a_ph_ring), .ph_vld(a_ph_vld)
   );

   ring_count #(.DW(16), .CW(4)) u_b (
      .clk_sys(clk_sys), .rst_n(rst_n), .sm_data(sm_data), .sm_vld(sm_vld),
      .cfg_th(cfg_th), .cfg_hys(cfg_hys), .cfg_mode(cfg_mode),
      .stu_now_hit(stu_now_hit), .stu_now_lock(stu_now_lock), .force_end(force_end),
      .stu_ring(b_ring), .stu_first(b_first), .stu_ovf(b_ovf),
      .ph_ring(b_ph_ring), .ph_vld(b_ph_vld)
   );

   // Reference model: window flags, unbounded event count and age, clamped on capture.
   int m_lvl, m_hitd, in_win, held, n_evt, age, first_age;
   int exp_ring[2], exp_first[2], exp_ovf[2];
   int exp_vld;
   int maxv[2] = '{65535, 15};

   function automatic int min2(int x, int y);
      return (x < y) ? x : y;
   endfunction

   task automatic model_reset();
      m_lvl = 0; m_hitd = 0; in_win = 0; held = 0;
      n_evt = 0; age = 0; first_age = 0; exp_vld = 0;
      for (int k = 0; k < 2; k++) begin
         exp_ring[k] = 0; exp_first[k] = 0; exp_ovf[k] = 0;
      end
   endtask

   task automatic model_step();
      int lo, nl, ev, op, cl, nv;
      if (!rst_n) begin
         model_reset();
         return;
      end
      lo = (int'(cfg_th) > int'(cfg_hys)) ? int'(cfg_th) - int'(cfg_hys) : 0;
      nl = m_lvl;
      if (sm_vld) begin
         if (int'(sm_data) >= int'(cfg_th)) nl = 1;
         else if (int'(sm_data) < lo) nl = 0;
      end
      if (cfg_mode == 2'd0)      ev = (m_lvl == 0 && nl == 1) ? 1 : 0;
      else if (cfg_mode == 2'd1) ev = (m_lvl == 1 && nl == 0) ? 1 : 0;
      else                       ev = (m_lvl != nl) ? 1 : 0;
      op = (stu_now_hit && m_hitd == 0) ? 1 : 0;
      cl = (!stu_now_hit && m_hitd == 1) ? 1 : 0;
      nv = 0;
      if (in_win == 1) begin
         age++;
         if (ev == 1) begin
            n_evt++;
            if (n_evt == 1) first_age = age;
         end
         if (cl == 1) begin
            for (int k = 0; k < 2; k++) begin
               exp_ring[k]  = min2(1 + n_evt, maxv[k]);
               exp_first[k] = (n_evt > 0) ? min2(first_age, maxv[k]) : maxv[k];
               exp_ovf[k]   = (1 + n_evt > maxv[k]) ? 1 : 0;
            end
            nv = force_end ? 0 : 1;
         end
      end
      exp_vld = nv;
      if (force_end) begin
         in_win = 0; held = 0;
      end else if (op == 1) begin
         in_win = 1; held = 0; n_evt = 0; age = 0;
      end else if (in_win == 1 && cl == 1) begin
         in_win = 0; held = stu_now_lock ? 1 : 0;
      end else if (held == 1 && !stu_now_lock) begin
         held = 0;
      end
      m_hitd = stu_now_hit ? 1 : 0;
      m_lvl = nl;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("a_ring",    32'(a_ring),    32'(exp_ring[0]));
      chk("a_first",   32'(a_first),   32'(exp_first[0]));
      chk("a_ovf",     32'(a_ovf),     32'(exp_ovf[0]));
      chk("a_ph_ring", 32'(a_ph_ring), 32'(exp_ring[0]));
      chk("a_ph_vld",  32'(a_ph_vld),  32'(exp_vld));
      chk("b_ring",    32'(b_ring),    32'(exp_ring[1]));
      chk("b_first",   32'(b_first),   32'(exp_first[1]));
      chk("b_ovf",     32'(b_ovf),     32'(exp_ovf[1]));
      chk("b_ph_ring", 32'(b_ph_ring), 32'(exp_ring[1]));
      chk("b_ph_vld",  32'(b_ph_vld),  32'(exp_vld));
   endtask

   task automatic step();
      model_step();
      @(posedge clk_sys);
      #1;
      check_all();
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse();
      sm_data = 16'd120; step();
      sm_data = 16'd80;  step();
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      cyc(2);
      chk("reset_first", 32'(a_first), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Five rising crossings in a 50-cycle window.
      cfg_mode = 2'd0; cfg_th = 16'd100; cfg_hys = 16'd10; sm_data = 16'd80;
      cyc(2);
      stu_now_hit = 1'b1;
      cyc(2);
      for (int i = 0; i < 5; i++) pulse();
      cyc(38);
      stu_now_hit = 1'b0;
      step();
      chk("t33_ring", 32'(a_ring), 32'd6);
      chk("t33_vld", 32'(a_ph_vld), 32'd1);
      step();
      chk("t33_vld_off", 32'(a_ph_vld), 32'd0);

      // Hysteresis suppresses chatter; zero hysteresis counts every re-rise.
      foreach (maxv[h]) begin
         cfg_hys = (h == 0) ? 16'd10 : 16'd0;
         sm_data = 16'd80;
         cyc(2);
         stu_now_hit = 1'b1; step();
         sm_data = 16'd105; step();
         for (int i = 0; i < 4; i++) begin
            sm_data = 16'd95;  step();
            sm_data = 16'd105; step();
         end
         stu_now_hit = 1'b0; step();
         chk("t34_ring", 32'(a_ring), (h == 0) ? 32'd2 : 32'd6);
      end

      // Both-edge and falling-edge modes.
      cfg_hys = 16'd10;
      for (int md = 2; md >= 1; md--) begin
         cfg_mode = 2'(md);
         sm_data = 16'd80;
         cyc(2);
         stu_now_hit = 1'b1; step();
         for (int i = 0; i < 3; i++) pulse();
         stu_now_hit = 1'b0; step();
         chk("t35_ring", 32'(a_ring), (md == 2) ? 32'd7 : 32'd4);
      end

      // 20 rising crossings saturate the 4-bit counter.
      cfg_mode = 2'd0;
      cyc(2);
      stu_now_hit = 1'b1; step();
      for (int i = 0; i < 20; i++) pulse();
      stu_now_hit = 1'b0; step();
      chk("t36_b_ring", 32'(b_ring), 32'd15);
      chk("t36_b_ovf", 32'(b_ovf), 32'd1);
      chk("t36_a_ring", 32'(a_ring), 32'd21);

      // Lock across close, reopen restarts, lock release keeps results.
      stu_now_lock = 1'b1;
      cyc(2);
      stu_now_hit = 1'b1; step();
      pulse(); pulse();
      stu_now_hit = 1'b0; step();
      chk("t37_ring_a", 32'(a_ring), 32'd3);
      step();
      stu_now_hit = 1'b1; cyc(2);
      stu_now_hit = 1'b0; step();
      chk("t37_ring_b", 32'(a_ring), 32'd1);
      stu_now_lock = 1'b0;
      cyc(3);
      chk("t37_hold", 32'(a_ring), 32'd1);
      chk("t37_vld", 32'(a_ph_vld), 32'd0);

      // force_end on the close cycle still captures but suppresses ph_vld.
      stu_now_hit = 1'b1; step();
      pulse();
      stu_now_hit = 1'b0; force_end = 1'b1; step();
      chk("t38_fe_ring", 32'(a_ring), 32'd2);
      chk("t38_fe_vld", 32'(a_ph_vld), 32'd0);
      force_end = 1'b0;
      cyc(2);

      // Asynchronous reset in the middle of a window.
      stu_now_hit = 1'b1; step();
      pulse(); pulse();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("t38_rst_first", 32'(a_first), 32'd0);
      stu_now_hit = 1'b0;
      cyc(2);
      #3;
      rst_n = 1'b1;
      cyc(4);

      // Randomized windows with config changes between windows.
      for (int w = 0; w < 60; w++) begin
         cfg_th = 16'($urandom_range(200, 50));
         cfg_hys = 16'($urandom_range(120, 0));
         cfg_mode = 2'($urandom_range(3, 0));
         stu_now_lock = ($urandom_range(1, 0) == 1);
         for (int i = 0, n = int'($urandom_range(4, 1)); i < n; i++) begin
            sm_data = 16'($urandom_range(255, 0));
            sm_vld = ($urandom_range(3, 0) != 0);
            step();
         end
         stu_now_hit = 1'b1;
         for (int i = 0, n = int'($urandom_range(30, 3)); i < n; i++) begin
            sm_data = 16'($urandom_range(255, 0));
            sm_vld = ($urandom_range(3, 0) != 0);
            force_end = ($urandom_range(39, 0) == 0);
            step();
         end
         force_end = ($urandom_range(7, 0) == 0);
         stu_now_hit = 1'b0;
         step();
         force_end = 1'b0;
         if ($urandom_range(1, 0) == 1) stu_now_lock = 1'b0;
         step();
      end
      sm_vld = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ring_count.md
RING_COUNT -- requirements
Module: ring_count

Interface
REQ-001 SHALL have parameter DW, default 16, width of sample data, threshold and hysteresis.
REQ-002 SHALL have parameter CW, default 16, width of ring counter and first-crossing timer.
REQ-003 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sm_data  in  DW  sample stream.
REQ-006 SHALL have port sm_vld  in  1  sample qualifier; samples with sm_vld=0 are ignored.
REQ-007 SHALL have port cfg_th  in  DW  upper threshold.
REQ-008 SHALL have port cfg_hys  in  DW  hysteresis; lower threshold lo = cfg_th - cfg_hys, saturating at 0.
REQ-009 SHALL have port cfg_mode  in  2  edge select: 0 rising, 1 falling, 2 both, 3 treated as 2.
REQ-010 SHALL have port stu_now_hit  in  1  count window; level-sensitive.
REQ-011 SHALL have port stu_now_lock  in  1  hold count after the window closes.
REQ-012 SHALL have port force_end  in  1  abort; synchronous clear.
REQ-013 SHALL have port stu_ring  out  CW  last captured ring count.
REQ-014 SHALL have port stu_first  out  CW  captured cycles from window open to first counted crossing.
REQ-015 SHALL have port stu_ovf  out  1  captured counter-saturation flag.
REQ-016 SHALL have port ph_ring  out  CW  equals stu_ring.
REQ-017 SHALL have port ph_vld  out  1  one-cycle result pulse.

Function
REQ-018 SHALL keep level flag lvl, updated only when sm_vld=1: set when sm_data >= cfg_th, cleared when sm_data < lo, otherwise held.
REQ-019 SHALL produce rise_evt when lvl goes 0->1 and fall_evt when lvl goes 1->0; evt = rise_evt (mode 0), fall_evt (mode 1), either (mode 2/3).
REQ-020 SHALL register stu_now_hit once; open = hit & ~hit_d, close = ~hit & hit_d.
REQ-021 SHALL run FSM states IDLE, HIT, LOCK: IDLE/LOCK -> HIT on open; HIT -> LOCK on close with stu_now_lock=1; HIT -> IDLE on close with stu_now_lock=0; LOCK -> IDLE when stu_now_lock=0 and no open.
REQ-022 SHALL load cnt=1, ovf=0, tmr=0, first=all-ones on open; an evt in the open cycle is not added.
REQ-023 SHALL, in HIT after the open cycle, increment cnt by 1 on evt, saturating at 2^CW-1; an evt arriving at saturation sets ovf=1.
REQ-024 SHALL increment tmr each HIT cycle (saturating at 2^CW-1) and copy tmr into first on the first counted evt only.
REQ-025 SHALL hold cnt, ovf, first in LOCK and clear them (cnt=0, ovf=0) on entry to IDLE.
REQ-026 SHALL on close capture stu_ring<=cnt, stu_first<=first, stu_ovf<=ovf, including an evt on that same cycle (cnt+1 captured).
REQ-027 SHALL assert ph_vld exactly one cycle after close, only if force_end=0 in the close cycle.
REQ-028 SHALL on force_end clear cnt, ovf, tmr and go to IDLE, with priority over open/evt; capture on a simultaneous close still occurs (pre-clear values), ph_vld suppressed.
REQ-029 SHALL leave stu_* unchanged outside close cycles, including in LOCK and after force_end.
REQ-030 SHALL treat cfg_* as static during a window; changes take effect on the next sample.

Reset
REQ-031 SHALL on rst_n=0 asynchronously set state IDLE, lvl=0, hit_d=0, cnt=0, tmr=0, first=all-ones, ovf=0, stu_ring=0, stu_first=0, stu_ovf=0, ph_vld=0.
REQ-032 SHALL on reset mid-window discard the window; no ph_vld follows reset release until a new open/close pair.

Verification
REQ-033 SHALL pass: mode 0, th=100, hys=10, hit 50 cycles, sm_data toggling 80/120 five times -> stu_ring=6, ph_vld one pulse one cycle after close.
REQ-034 SHALL pass: hys=10, data oscillating 95/105 around th=100 after one rise -> only 1 counted, stu_ring=2; hys=0 -> every 95->105 counted.
REQ-035 SHALL pass: mode 2, three full pulses above th -> stu_ring=7; mode 1 -> stu_ring=4.
REQ-036 SHALL pass: CW=4, 20 rising crossings -> stu_ring=15, stu_ovf=1.
REQ-037 SHALL pass: lock=1 across close, hit reopens -> count restarts at 1; lock drops -> cnt=0, stu_ring unchanged.
REQ-038 SHALL pass: force_end on close cycle -> stu_ring captured, ph_vld=0; rst_n low mid-window -> all outputs 0, stu_first=0.
